lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl.sv | 84 ++++++++
 tb/tb_lsu_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit sequencer with sub-word extract, read-modify-write
// stores and misalignment detection over a single-word memory port.
module lsu_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_write,
   output logic        mem_read,
   input  logic [31:0] mem_rdata
);
   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
   state_t state, next;
   logic [31:0] addr, wdata, word, ext, mask;
   logic [15:0] lane;
   logic [4:0]  sh;
   logic [1:0]  size;
   logic        sgn, wr, err, accept, mis;

   assign accept = state == IDLE && req_valid;
   assign mis = req_size == 2'd3 || (req_size == 2'd1 && req_addr[0]) ||
                (req_size == 2'd2 && req_addr[1:0] != 2'b00);
   // Bit offset of the selected byte or half lane within the word
   assign sh = size == 2'd0 ? {addr[1:0], 3'b000} : {addr[1], 4'b0000};
   assign lane = 16'(mem_rdata >> sh);
   assign ext = size == 2'd0 ? {{24{sgn & lane[7]}}, lane[7:0]} :
                size == 2'd1 ? {{16{sgn & lane[15]}}, lane} : mem_rdata;
   assign mask = (size == 2'd0 ? 32'h0000_00ff : 32'h0000_ffff) << sh;
   assign mem_wdata = size == 2'd2 ? wdata : (word & ~mask) | ((wdata << sh) & mask);
   assign mem_addr = {addr[31:2], 2'b00};
   assign mem_read = state == RD;
   assign mem_write = state == WR;
   assign req_ready = state == IDLE;
   assign resp_valid = state == RESP;
   assign resp_err = resp_valid & err;

   always_ff @(posedge clk)
      if (!rst_n) state <= IDLE;
      else state <= next;

   always_comb begin
      next = IDLE;
      next = state == IDLE ? (req_valid ? (mis ? RESP : (req_write && req_size == 2'd2) ? WR : RD) : IDLE) :
             state == RD   ? (wr ? WR : RESP) :
             state == WR   ? RESP : IDLE;
   end

   always_ff @(posedge clk)
      if (!rst_n) begin
         addr <= '0;
         wdata <= '0;
         word <= '0;
         size <= '0;
         sgn <= 1'b0;
         wr <= 1'b0;
         err <= 1'b0;
         resp_rdata <= '0;
      end else begin
         if (accept) begin
            addr <= req_addr;
            wdata <= req_wdata;
            size <= req_size;
            sgn <= req_signed;
            wr <= req_write;
            err <= mis;
         end
         if (accept && mis) resp_rdata <= '0;
         if (state == RD) begin
            word <= mem_rdata;
            if (!wr) resp_rdata <= ext;
         end
         if (state == WR) resp_rdata <= '0;
      end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed checks of lsu_ctrl against a small word memory,
// with hand-computed responses, latencies and memory contents.
module tb_lsu_ctrl;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic        req_ready, resp_valid, resp_err, mem_write, mem_read;
   logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata, last_wd = '0;
   logic [31:0] mem [0:15];
   int          writes = 0, vectors = 0, errs = 0;

   lsu_ctrl dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
      .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
      .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_read(mem_read),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;
   assign mem_rdata = mem[mem_addr[5:2]];
   always @(posedge clk)
      if (mem_write) begin
         mem[mem_addr[5:2]] <= mem_wdata;
         last_wd <= mem_wdata;
         writes <= writes + 1;
      end

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One request; response expected lat cycles after acceptance, nw memory writes
   task automatic xact(string tag, logic w, logic [1:0] sz, logic sg, logic [31:0] a,
                       logic [31:0] wd, int lat, logic [31:0] er, logic ee, int nw);
      int w0;
      w0 = writes;
      @(negedge clk);
      chk({tag, " ready"}, req_ready, 1);
      req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
      req_addr = a; req_wdata = wd;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int k = 1; k <= lat; k++) begin
         @(negedge clk);
         chk({tag, " valid"}, resp_valid, k == lat);
      end
      chk({tag, " rdata"}, resp_rdata, er);
      chk({tag, " err"}, resp_err, ee);
      chk({tag, " writes"}, writes - w0, nw);
   endtask

   // Hold req_valid for 12 cycles and measure acceptance spacing
   task automatic b2b(string tag, logic w, logic [1:0] sz, logic [31:0] a,
                      logic [31:0] wd, int sp, int nexp);
      int last, nacc, nresp;
      last = -1; nacc = 0; nresp = 0;
      @(negedge clk);
      req_valid = 1'b1; req_write = w; req_size = sz; req_signed = 1'b0;
      req_addr = a; req_wdata = wd;
      for (int c = 0; c < 12; c++) begin
         if (req_ready) begin
            if (last >= 0) chk({tag, " spacing"}, c - last, sp);
            last = c;
            nacc++;
         end
         if (resp_valid) nresp++;
         @(negedge clk);
      end
      req_valid = 1'b0;
      chk({tag, " accepts"}, nacc, nexp);
      chk({tag, " resps"}, nresp, nexp);
   endtask

   initial begin
      int w0;
      for (int i = 0; i < 16; i++) mem[i] = '0;
      mem[0] = 32'hDEADBEEF;
      mem[1] = 32'hCAFEBABE;
      mem[2] = 32'h12345678;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst ready", req_ready, 1);
      chk("rst valid", resp_valid, 0);
      chk("rst err", resp_err, 0);
      chk("rst rdata", resp_rdata, 0);
      chk("rst memrd", mem_read, 0);
      chk("rst memwr", mem_write, 0);
      chk("rst addr", mem_addr, 0);

      xact("lb s a0", 0, 2'd0, 1, 32'd0, 0, 2, 32'hFFFFFFEF, 0, 0);
      @(negedge clk);
      chk("rdata hold", resp_rdata, 32'hFFFFFFEF);
      xact("lbu a3", 0, 2'd0, 0, 32'd3, 0, 2, 32'h000000DE, 0, 0);
      xact("lh s a2", 0, 2'd1, 1, 32'd2, 0, 2, 32'hFFFFDEAD, 0, 0);
      xact("lw a8", 0, 2'd2, 0, 32'd8, 0, 2, 32'h12345678, 0, 0);
      xact("sb a5", 1, 2'd0, 0, 32'd5, 32'h00000011, 3, 32'h0, 0, 1);
      chk("sb a5 wdata", last_wd, 32'hCAFE11BE);
      xact("lw a4", 0, 2'd2, 0, 32'd4, 0, 2, 32'hCAFE11BE, 0, 0);
      xact("sw a6 mis", 1, 2'd2, 0, 32'd6, 32'h55555555, 1, 32'h0, 1, 0);
      xact("lh a1 mis", 0, 2'd1, 1, 32'd1, 0, 1, 32'h0, 1, 0);
      xact("lw a4 again", 0, 2'd2, 0, 32'd4, 0, 2, 32'hCAFE11BE, 0, 0);
      xact("sh a14", 1, 2'd1, 0, 32'd14, 32'hABCD1234, 3, 32'h0, 0, 1);
      chk("sh a14 wdata", last_wd, 32'h12340000);
      xact("lhu a14", 0, 2'd1, 0, 32'd14, 0, 2, 32'h00001234, 0, 0);
      xact("sw a12", 1, 2'd2, 0, 32'd12, 32'h87654321, 2, 32'h0, 0, 1);
      xact("lb s a12", 0, 2'd0, 1, 32'd12, 0, 2, 32'h00000021, 0, 0);
      xact("lb s a15", 0, 2'd0, 1, 32'd15, 0, 2, 32'hFFFFFF87, 0, 0);

      b2b("b2b lw", 0, 2'd2, 32'd8, 0, 3, 4);
      b2b("b2b sb", 1, 2'd0, 32'd9, 32'h00000055, 4, 3);
      xact("lw a8 after", 0, 2'd2, 0, 32'd8, 0, 2, 32'h12345578, 0, 0);

      w0 = writes;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_addr = 32'd0;
      req_wdata = 32'h00000077;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("abort in rd", mem_read, 1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort memwr", mem_write, 0);
      chk("abort valid", resp_valid, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort ready", req_ready, 1);
      chk("abort valid2", resp_valid, 0);
      repeat (3) @(negedge clk);
      chk("abort writes", writes - w0, 0);
      xact("lw a0 after abort", 0, 2'd2, 0, 32'd0, 0, 2, 32'hDEADBEEF, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
